fftbank_arbiter: RTL and testbench
==================================

# fftbank_arbiter

Parametrised ownership arbiter and port multiplexer between the MicroBlaze host and the FFT core for a bank of dual-port BRAMs (default 32 banks × 512 × 16 bit). It replaces the fixed tristate bank wiring with explicit request/grant ownership, a one-cycle turnaround, host read-valid signalling and an access-violation flag. It sits between the FFT core, the host bus bridge and the BRAM primitives.

## Interface
- NBANKS, 32, number of dual-port BRAMs (power of two, ≥2)
- DW, 16, BRAM data width
- AW, 9, BRAM address width (row index)
- HAW, $clog2(NBANKS)+AW, host word address width (derived, not overridden)

- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- MB_req  in  1  host requests ownership, held high while owning
- MB_gnt  out  1  host owns banks
- MB_addr  in  HAW  {bank, row}
- MB_din  in  DW  host write data
- MB_we  in  1  host write strobe
- MB_re  in  1  host read strobe
- MB_dout  out  DW  host read data
- MB_rvalid  out  1  MB_dout valid
- MB_err  out  1  sticky: host strobe while not granted
- MB_err_clr  in  1  clears MB_err
- FFT_req  in  1  core requests ownership, held while owning
- FFT_gnt  out  1  core owns banks
- FFT_addra / FFT_addrb  in  NBANKS*AW  per-bank addresses; bank i at [i*AW +: AW]
- FFT_dina / FFT_dinb  in  NBANKS*DW  per-bank write data
- FFT_wea / FFT_web  in  NBANKS  per-bank write enables
- FFT_ena / FFT_enb  in  NBANKS  per-bank port enables
- FFT_douta / FFT_doutb  out  NBANKS*DW  per-bank read data (bank output pass-through)
- BR_addra / BR_addrb  out  NBANKS*AW  to BRAMs
- BR_dina / BR_dinb  out  NBANKS*DW  to BRAMs
- BR_wea / BR_web / BR_ena / BR_enb  out  NBANKS  to BRAMs
- BR_douta / BR_doutb  in  NBANKS*DW  from BRAMs (1-cycle synchronous read)

## Operation
- States: IDLE, HOST, CORE, TURN. State, MB_gnt, FFT_gnt registered; MB_gnt=1 iff HOST, FFT_gnt=1 iff CORE.
- IDLE: only MB_req → HOST; only FFT_req → CORE; both → owner opposite to last_owner (round-robin); neither → stay.
- HOST: MB_req low → TURN, last_owner=HOST. CORE: FFT_req low → TURN, last_owner=CORE. Requests from the other side are ignored until IDLE.
- TURN: exactly one cycle, all bank enables 0; → IDLE.
- HOST muxing: bank b = MB_addr[HAW-1:AW]; only bank b port A enabled when MB_re|MB_we; BR_addra=row, BR_dina=MB_din, BR_wea=MB_we. MB_we and MB_re together = write (read ignored). All port B enables 0.
- CORE muxing: all FFT_* bank signals pass straight to BR_* combinationally.
- IDLE/TURN/reset: all BR_en*/BR_we* = 0; addresses/data don't-care (driven 0).
- Host read: registered bank index and rvalid; MB_rvalid=1 the cycle after an accepted MB_re; MB_dout = BR_douta of the registered bank, 0 when MB_rvalid=0.
- MB_err set when MB_re|MB_we while state≠HOST; MB_err_clr same cycle as a new violation → stays set (set wins).

## Timing
- Reset values: state IDLE, last_owner=HOST (core wins first tie), MB_gnt=0, FFT_gnt=0, MB_rvalid=0, MB_dout=0, MB_err=0, all BR enables 0.
- Grant latency: req sampled high at edge k in IDLE → gnt high after edge k (visible cycle k+1).
- Release: req low sampled at edge k → gnt low cycle k+1 (TURN), other side may be granted cycle k+3 earliest.
- Host read issued in last HOST cycle: rvalid still delivered during TURN.
- Reset mid-read: MB_rvalid cleared, read lost.

## Structure
- Package fftbank_pkg: state enum (IDLE, HOST, CORE, TURN), owner encoding, default NBANKS/DW/AW constants.
- Sub-module fftbank_port_mux: one bank's A/B mux (host/core/off select), generated NBANKS times; the FSM, host read pipeline and error flag live in the top level.

## Test plan
- Reset, then MB_req=1 → MB_gnt=1 next cycle; write 0x1234 to addr {bank 5, row 17}; only BR_wea[5]=1 with BR_addra=17.
- Host read back bank 5 row 17 → MB_rvalid one cycle after MB_re, MB_dout=0x1234; other banks' enables stay 0.
- MB_req and FFT_req both rise in IDLE after reset → FFT_gnt first; release FFT_req → TURN one cycle → MB_gnt; next tie → FFT_gnt.
- CORE state: drive FFT_addrb bank 31 = 0x1FF, FFT_web[31]=1 → BR_addrb/BR_web match same cycle; MB_we pulse → no BRAM effect, MB_err=1 until MB_err_clr.
- Host read on last HOST cycle, MB_req drops → MB_rvalid during TURN with correct data, all BR enables 0.
- rst asserted mid-CORE → next cycle FFT_gnt=0, all enables 0, state IDLE; FFT_req held → FFT_gnt re-asserts one cycle after rst drops.

Source files
------------

// File: rtl/fftbank_pkg.sv
// Shared types and default geometry for the FFT bank ownership arbiter.
package fftbank_pkg;

    localparam int DEF_NBANKS = 32;
    localparam int DEF_DW     = 16;
    localparam int DEF_AW     = 9;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOST = 2'd1,
        ST_CORE = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    // Owner of the most recently released grant, used for round-robin ties
    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_CORE = 1'b1
    } owner_t;

    // Per-bank port mux source select
    typedef enum logic [1:0] {
        SEL_OFF  = 2'd0,
        SEL_HOST = 2'd1,
        SEL_CORE = 2'd2
    } sel_t;

endpackage

// File: rtl/fftbank_arbiter_if.sv
// Host (MicroBlaze bridge) side bus of the bank arbiter.
interface fftbank_arbiter_if #(
    parameter int NBANKS = 32,
    parameter int DW     = 16,
    parameter int AW     = 9
);
    localparam int HAW = $clog2(NBANKS) + AW;

    logic           MB_req;
    logic           MB_gnt;
    logic [HAW-1:0] MB_addr;
    logic [DW-1:0]  MB_din;
    logic           MB_we;
    logic           MB_re;
    logic [DW-1:0]  MB_dout;
    logic           MB_rvalid;
    logic           MB_err;
    logic           MB_err_clr;

    // Host bridge drives requests and strobes
    modport master (
        output MB_req, MB_addr, MB_din, MB_we, MB_re, MB_err_clr,
        input  MB_gnt, MB_dout, MB_rvalid, MB_err
    );

    // Arbiter answers with grant, read data and error status
    modport slave (
        input  MB_req, MB_addr, MB_din, MB_we, MB_re, MB_err_clr,
        output MB_gnt, MB_dout, MB_rvalid, MB_err
    );
endinterface

// File: rtl/fftbank_port_mux.sv
// One bank's A/B port multiplexer: host drives port A only, core drives both, off forces idle.
module fftbank_port_mux
    import fftbank_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 9
) (
    input  sel_t          sel_i,
    input  logic          host_en_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_din_i,
    input  logic [AW-1:0] fft_addra_i,
    input  logic [AW-1:0] fft_addrb_i,
    input  logic [DW-1:0] fft_dina_i,
    input  logic [DW-1:0] fft_dinb_i,
    input  logic          fft_wea_i,
    input  logic          fft_web_i,
    input  logic          fft_ena_i,
    input  logic          fft_enb_i,
    output logic [AW-1:0] br_addra_o,
    output logic [AW-1:0] br_addrb_o,
    output logic [DW-1:0] br_dina_o,
    output logic [DW-1:0] br_dinb_o,
    output logic          br_wea_o,
    output logic          br_web_o,
    output logic          br_ena_o,
    output logic          br_enb_o
);

    // Select the bank's port drivers; everything idles to zero when unowned
    always_comb begin
        br_addra_o = '0;
        br_addrb_o = '0;
        br_dina_o  = '0;
        br_dinb_o  = '0;
        br_wea_o   = 1'b0;
        br_web_o   = 1'b0;
        br_ena_o   = 1'b0;
        br_enb_o   = 1'b0;
        case (sel_i)
            SEL_HOST: begin
                br_addra_o = host_addr_i;
                br_dina_o  = host_din_i;
                br_ena_o   = host_en_i;
                br_wea_o   = host_en_i & host_we_i;
            end
            SEL_CORE: begin
                br_addra_o = fft_addra_i;
                br_addrb_o = fft_addrb_i;
                br_dina_o  = fft_dina_i;
                br_dinb_o  = fft_dinb_i;
                br_wea_o   = fft_wea_i;
                br_web_o   = fft_web_i;
                br_ena_o   = fft_ena_i;
                br_enb_o   = fft_enb_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fftbank_arbiter.sv
// Ownership arbiter between host and FFT core for a bank of dual-port BRAMs.
module fftbank_arbiter
    import fftbank_pkg::*;
#(
    parameter int NBANKS = DEF_NBANKS,
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW
) (
    input  logic               clk,
    input  logic               rst,
    fftbank_arbiter_if.slave   mb,
    input  logic               FFT_req,
    output logic               FFT_gnt,
    input  logic [NBANKS*AW-1:0] FFT_addra,
    input  logic [NBANKS*AW-1:0] FFT_addrb,
    input  logic [NBANKS*DW-1:0] FFT_dina,
    input  logic [NBANKS*DW-1:0] FFT_dinb,
    input  logic [NBANKS-1:0]    FFT_wea,
    input  logic [NBANKS-1:0]    FFT_web,
    input  logic [NBANKS-1:0]    FFT_ena,
    input  logic [NBANKS-1:0]    FFT_enb,
    output logic [NBANKS*DW-1:0] FFT_douta,
    output logic [NBANKS*DW-1:0] FFT_doutb,
    output logic [NBANKS*AW-1:0] BR_addra,
    output logic [NBANKS*AW-1:0] BR_addrb,
    output logic [NBANKS*DW-1:0] BR_dina,
    output logic [NBANKS*DW-1:0] BR_dinb,
    output logic [NBANKS-1:0]    BR_wea,
    output logic [NBANKS-1:0]    BR_web,
    output logic [NBANKS-1:0]    BR_ena,
    output logic [NBANKS-1:0]    BR_enb,
    input  logic [NBANKS*DW-1:0] BR_douta,
    input  logic [NBANKS*DW-1:0] BR_doutb
);

    localparam int BW  = $clog2(NBANKS);
    localparam int HAW = BW + AW;

    state_t         state_q, state_d;
    owner_t         last_owner_q, last_owner_d;
    logic           mb_gnt_q, fft_gnt_q;
    logic           rvalid_q;
    logic [BW-1:0]  rd_bank_q;
    logic           err_q;

    logic [BW-1:0]  host_bank;
    logic [AW-1:0]  host_row;
    logic           host_acc;
    logic           host_rd;
    sel_t           sel;
    logic [DW-1:0]  douta_bank [NBANKS];

    assign host_bank = mb.MB_addr[HAW-1:AW];
    assign host_row  = mb.MB_addr[AW-1:0];
    assign host_acc  = mb.MB_re | mb.MB_we;
    // A simultaneous write strobe turns the access into a write
    assign host_rd   = (state_q == ST_HOST) & mb.MB_re & ~mb.MB_we;

    // Next-state logic: round-robin tie in IDLE, release through a one-cycle TURN
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ST_IDLE: begin
                if (mb.MB_req && FFT_req)
                    state_d = (last_owner_q == OWN_HOST) ? ST_CORE : ST_HOST;
                else if (mb.MB_req)
                    state_d = ST_HOST;
                else if (FFT_req)
                    state_d = ST_CORE;
            end
            ST_HOST: begin
                if (!mb.MB_req) begin
                    state_d      = ST_TURN;
                    last_owner_d = OWN_HOST;
                end
            end
            ST_CORE: begin
                if (!FFT_req) begin
                    state_d      = ST_TURN;
                    last_owner_d = OWN_CORE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, grants, host read pipeline and sticky error register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_HOST;
            mb_gnt_q     <= 1'b0;
            fft_gnt_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rd_bank_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            mb_gnt_q     <= (state_d == ST_HOST);
            fft_gnt_q    <= (state_d == ST_CORE);
            rvalid_q     <= host_rd;
            if (host_rd)
                rd_bank_q <= host_bank;
            if (host_acc && state_q != ST_HOST)
                err_q <= 1'b1;
            else if (mb.MB_err_clr)
                err_q <= 1'b0;
        end
    end

    always_comb begin
        sel = SEL_OFF;
        if (state_q == ST_HOST)
            sel = SEL_HOST;
        else if (state_q == ST_CORE)
            sel = SEL_CORE;
    end

    assign mb.MB_gnt    = mb_gnt_q;
    assign FFT_gnt      = fft_gnt_q;
    assign mb.MB_rvalid = rvalid_q;
    assign mb.MB_err    = err_q;
    assign mb.MB_dout   = rvalid_q ? douta_bank[rd_bank_q] : '0;
    assign FFT_douta    = BR_douta;
    assign FFT_doutb    = BR_doutb;

    for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
        assign douta_bank[gi] = BR_douta[gi*DW +: DW];

        fftbank_port_mux #(
            .DW (DW),
            .AW (AW)
        ) u_mux (
            .sel_i       (sel),
            .host_en_i   (host_acc && host_bank == BW'(gi)),
            .host_we_i   (mb.MB_we),
            .host_addr_i (host_row),
            .host_din_i  (mb.MB_din),
            .fft_addra_i (FFT_addra[gi*AW +: AW]),
            .fft_addrb_i (FFT_addrb[gi*AW +: AW]),
            .fft_dina_i  (FFT_dina[gi*DW +: DW]),
            .fft_dinb_i  (FFT_dinb[gi*DW +: DW]),
            .fft_wea_i   (FFT_wea[gi]),
            .fft_web_i   (FFT_web[gi]),
            .fft_ena_i   (FFT_ena[gi]),
            .fft_enb_i   (FFT_enb[gi]),
            .br_addra_o  (BR_addra[gi*AW +: AW]),
            .br_addrb_o  (BR_addrb[gi*AW +: AW]),
            .br_dina_o   (BR_dina[gi*DW +: DW]),
            .br_dinb_o   (BR_dinb[gi*DW +: DW]),
            .br_wea_o    (BR_wea[gi]),
            .br_web_o    (BR_web[gi]),
            .br_ena_o    (BR_ena[gi]),
            .br_enb_o    (BR_enb[gi])
        );
    end

endmodule

// File: tb/tb_fftbank_arbiter.sv
// Directed bench for fftbank_arbiter with a behavioural BRAM bank and read-data scoreboard.
module tb_fftbank_arbiter;
    localparam int NB = 32;
    localparam int DW = 16;
    localparam int AW = 9;

    logic clk = 1'b0;
    logic rst;
    logic              FFT_req, FFT_gnt;
    logic [NB*AW-1:0]  FFT_addra, FFT_addrb, BR_addra, BR_addrb;
    logic [NB*DW-1:0]  FFT_dina, FFT_dinb, FFT_douta, FFT_doutb;
    logic [NB*DW-1:0]  BR_dina, BR_dinb, BR_douta, BR_doutb;
    logic [NB-1:0]     FFT_wea, FFT_web, FFT_ena, FFT_enb;
    logic [NB-1:0]     BR_wea, BR_web, BR_ena, BR_enb;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mem [NB][1<<AW];

    fftbank_arbiter_if #(.NBANKS(NB), .DW(DW), .AW(AW)) mb ();

    fftbank_arbiter #(.NBANKS(NB), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .mb(mb),
        .FFT_req(FFT_req), .FFT_gnt(FFT_gnt),
        .FFT_addra(FFT_addra), .FFT_addrb(FFT_addrb),
        .FFT_dina(FFT_dina), .FFT_dinb(FFT_dinb),
        .FFT_wea(FFT_wea), .FFT_web(FFT_web),
        .FFT_ena(FFT_ena), .FFT_enb(FFT_enb),
        .FFT_douta(FFT_douta), .FFT_doutb(FFT_doutb),
        .BR_addra(BR_addra), .BR_addrb(BR_addrb),
        .BR_dina(BR_dina), .BR_dinb(BR_dinb),
        .BR_wea(BR_wea), .BR_web(BR_web),
        .BR_ena(BR_ena), .BR_enb(BR_enb),
        .BR_douta(BR_douta), .BR_doutb(BR_doutb)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port BRAMs, read-first, one-cycle read latency
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (BR_ena[b]) begin
                if (BR_wea[b]) mem[b][BR_addra[b*AW +: AW]] <= BR_dina[b*DW +: DW];
                BR_douta[b*DW +: DW] <= mem[b][BR_addra[b*AW +: AW]];
            end
            if (BR_enb[b]) begin
                if (BR_web[b]) mem[b][BR_addrb[b*AW +: AW]] <= BR_dinb[b*DW +: DW];
                BR_doutb[b*DW +: DW] <= mem[b][BR_addrb[b*AW +: AW]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_off(input string name);
        chk(name, {BR_ena | BR_enb | BR_wea | BR_web}, 32'h0);
    endtask

    // Read-data monitor: every rvalid must match the oldest expected host read
    always @(negedge clk) begin
        if (mb.MB_rvalid === 1'b1) begin
            if (exp_q.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
            else chk("rd_data", 32'(mb.MB_dout), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        rst = 1'b1;
        FFT_req = 1'b0; FFT_addra = '0; FFT_addrb = '0; FFT_dina = '0; FFT_dinb = '0;
        FFT_wea = '0; FFT_web = '0; FFT_ena = '1; FFT_enb = '1;
        mb.MB_req = 1'b0; mb.MB_addr = '0; mb.MB_din = '0;
        mb.MB_we = 1'b0; mb.MB_re = 1'b0; mb.MB_err_clr = 1'b0;
        repeat (3) step();
        chk("rst_mb_gnt", 32'(mb.MB_gnt), 32'd0);
        chk("rst_fft_gnt", 32'(FFT_gnt), 32'd0);
        chk("rst_rvalid", 32'(mb.MB_rvalid), 32'd0);
        chk("rst_dout", 32'(mb.MB_dout), 32'd0);
        chk("rst_err", 32'(mb.MB_err), 32'd0);
        chk_all_off("rst_enables");

        // Host grant, write then read back bank 5 row 17
        rst = 1'b0; FFT_ena = '0; FFT_enb = '0; mb.MB_req = 1'b1;
        step();
        chk("host_gnt", 32'(mb.MB_gnt), 32'd1);
        chk("host_fft_gnt", 32'(FFT_gnt), 32'd0);
        mb.MB_addr = {5'd5, 9'd17}; mb.MB_din = 16'h1234; mb.MB_we = 1'b1;
        #1;
        chk("wr_wea", BR_wea, 32'h0000_0020);
        chk("wr_ena", BR_ena, 32'h0000_0020);
        chk("wr_addra", 32'(BR_addra[5*AW +: AW]), 32'd17);
        chk("wr_dina", 32'(BR_dina[5*DW +: DW]), 32'h1234);
        chk("wr_enb", BR_enb, 32'h0);
        step();
        mb.MB_we = 1'b0; mb.MB_re = 1'b1; exp_q.push_back(16'h1234);
        #1;
        chk("rd_ena", BR_ena, 32'h0000_0020);
        chk("rd_wea", BR_wea, 32'h0);
        step();
        mb.MB_re = 1'b0;
        chk("rd_rvalid", 32'(mb.MB_rvalid), 32'd1);

        // Read in the last HOST cycle, delivered during TURN
        mb.MB_re = 1'b1; mb.MB_req = 1'b0; exp_q.push_back(16'h1234);
        step();
        mb.MB_re = 1'b0;
        chk("turn_mb_gnt", 32'(mb.MB_gnt), 32'd0);
        chk("turn_rvalid", 32'(mb.MB_rvalid), 32'd1);
        chk_all_off("turn_enables");
        chk("turn_err", 32'(mb.MB_err), 32'd0);
        step(); step();

        // Tie after reset goes to the core
        rst = 1'b1; step();
        rst = 1'b0; mb.MB_req = 1'b1; FFT_req = 1'b1;
        step();
        chk("tie1_fft_gnt", 32'(FFT_gnt), 32'd1);
        chk("tie1_mb_gnt", 32'(mb.MB_gnt), 32'd0);

        // Core pass-through and host violation
        FFT_addrb[31*AW +: AW] = 9'h1FF; FFT_dinb[31*DW +: DW] = 16'hBEEF;
        FFT_web[31] = 1'b1; FFT_enb[31] = 1'b1;
        FFT_ena[2] = 1'b1; FFT_addra[2*AW +: AW] = 9'd7;
        mb.MB_addr = {5'd3, 9'd2}; mb.MB_we = 1'b1;
        #1;
        chk("core_addrb", 32'(BR_addrb[31*AW +: AW]), 32'h1FF);
        chk("core_dinb", 32'(BR_dinb[31*DW +: DW]), 32'hBEEF);
        chk("core_web", BR_web, 32'h8000_0000);
        chk("core_enb", BR_enb, 32'h8000_0000);
        chk("core_ena", BR_ena, 32'h0000_0004);
        chk("core_addra", 32'(BR_addra[2*AW +: AW]), 32'd7);
        chk("core_wea", BR_wea, 32'h0);
        step();
        mb.MB_we = 1'b0; FFT_web = '0;
        chk("err_set", 32'(mb.MB_err), 32'd1);
        step();
        chk("core_doutb", 32'(FFT_doutb[31*DW +: DW]), 32'hBEEF);
        mb.MB_we = 1'b1; mb.MB_err_clr = 1'b1;
        step();
        mb.MB_we = 1'b0;
        chk("err_set_wins", 32'(mb.MB_err), 32'd1);
        step();
        mb.MB_err_clr = 1'b0;
        chk("err_cleared", 32'(mb.MB_err), 32'd0);

        // Core release: TURN, IDLE, then host
        FFT_req = 1'b0;
        step();
        chk("rel_fft_gnt", 32'(FFT_gnt), 32'd0);
        chk_all_off("rel_turn_enables");
        step();
        chk("rel_idle_mb_gnt", 32'(mb.MB_gnt), 32'd0);
        step();
        chk("rel_host_gnt", 32'(mb.MB_gnt), 32'd1);
        chk("host_enb_off", BR_enb, 32'h0);

        // Second tie after host released goes to the core
        mb.MB_req = 1'b0;
        step();
        mb.MB_req = 1'b1; FFT_req = 1'b1;
        step();
        chk("tie2_idle_fft_gnt", 32'(FFT_gnt), 32'd0);
        step();
        chk("tie2_fft_gnt", 32'(FFT_gnt), 32'd1);
        chk("tie2_mb_gnt", 32'(mb.MB_gnt), 32'd0);

        // Reset mid-CORE with request held
        rst = 1'b1;
        step();
        chk("rstc_fft_gnt", 32'(FFT_gnt), 32'd0);
        chk_all_off("rstc_enables");
        rst = 1'b0;
        step();
        chk("rstc_regrant", 32'(FFT_gnt), 32'd1);

        FFT_req = 1'b0; mb.MB_req = 1'b0;
        repeat (3) step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
